// File: rtl/imm_instr_encoder_pkg.sv
// rtl/imm_instr_encoder_pkg.sv - shared encodings, opcodes and state type for the immediate encoder
// Contents: ImmSrc format codes (same as the core's decode), RV32I opcode constants,
// shift funct3 codes, the controller state enum and a sign-extension range helper.
package imm_instr_encoder_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // I-type shifts carry funct7 in bits [31:25] and only a 5-bit shamt
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    // True when value equals the sign extension of value[msb:0], i.e. bits
    // [31:msb] are all zeros or all ones.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((value & mask) == 32'h0) || ((value & mask) == mask);
    endfunction

endpackage

// File: rtl/imm_instr_encoder_if.sv
// rtl/imm_instr_encoder_if.sv - field-input handshake and instruction-memory write bus
// Ports: in_valid/in_ready handshake with ImmSrc, imm, op, rd, rs1, rs2, funct3, funct7
// fields; mem_we/mem_addr/mem_wdata write strobe. master = loader side, slave = encoder.
interface imm_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        ImmSrc;
    logic [31:0]       imm;
    logic [6:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, ImmSrc, imm, op, rd, rs1, rs2, funct3, funct7,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, ImmSrc, imm, op, rd, rs1, rs2, funct3, funct7,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imm_instr_encoder_imm_scatter.sv
// rtl/imm_instr_encoder_imm_scatter.sv - combinational immediate scatter and range check
// Ports: imm_src, imm, op, rd, rs1, rs2, funct3, funct7 in; word (packed RV32I
// instruction) and in_range (immediate representable in the selected format) out.
module imm_scatter
    import imm_instr_encoder_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    output logic [31:0] word,
    output logic        in_range
);

    logic shift_form;

    assign shift_form = (imm_src == IMM_I) && ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));

    always_comb begin
        word     = 32'h0;
        in_range = 1'b0;
        case (imm_src)
            IMM_I: begin
                if (shift_form) begin
                    word     = {funct7, imm[4:0], rs1, funct3, rd, op};
                    in_range = (imm[31:5] == 27'h0);
                end else begin
                    word     = {imm[11:0], rs1, funct3, rd, op};
                    in_range = fits_signed(imm, 11);
                end
            end
            IMM_S: begin
                word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                in_range = fits_signed(imm, 11);
            end
            IMM_B: begin
                // B and J immediates are byte offsets with an implicit zero LSB
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                in_range = !imm[0] && fits_signed(imm, 12);
            end
            IMM_J: begin
                word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                in_range = !imm[0] && fits_signed(imm, 20);
            end
            default: begin
                word     = 32'h0;
                in_range = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// rtl/imm_instr_encoder.sv - two-stage instruction encoder and sequential instruction-memory writer
// Ports: clk, reset_n (async, active-low), start, stop; bus (slave: field handshake in,
// memory write strobe out); count (words written since start), err_range (sticky reject
// flag), full (last address written).
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    imm_instr_encoder_if.slave   bus,
    output logic [ADDR_W:0]      count,
    output logic                 err_range,
    output logic                 full
);

    localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W + 1)'(BASE_ADDR);

    state_t          state;
    logic [ADDR_W:0] wr_ptr;      // one bit wider than the address so it never wraps

    // Stage 1: captured fields
    logic            s1_valid;
    logic [1:0]      s1_src;
    logic [31:0]     s1_imm;
    logic [6:0]      s1_op;
    logic [4:0]      s1_rd;
    logic [4:0]      s1_rs1;
    logic [4:0]      s1_rs2;
    logic [2:0]      s1_funct3;
    logic [6:0]      s1_funct7;

    logic [31:0]     enc_word;
    logic            enc_in_range;
    logic [1:0]      inflight;
    logic            room;
    logic            accept;
    logic            write;
    logic            last_write;

    imm_scatter u_scatter (
        .imm_src  (s1_src),
        .imm      (s1_imm),
        .op       (s1_op),
        .rd       (s1_rd),
        .rs1      (s1_rs1),
        .rs2      (s1_rs2),
        .funct3   (s1_funct3),
        .funct7   (s1_funct7),
        .word     (enc_word),
        .in_range (enc_in_range)
    );

    // wr_ptr advances when a word is encoded, so the only accepted word not yet
    // reflected in wr_ptr is the one sitting in stage 1. A rejected word frees
    // its slot as soon as it leaves stage 1.
    assign inflight   = {1'b0, s1_valid};
    assign room       = (wr_ptr + (ADDR_W + 1)'(inflight)) <= LAST_PTR;
    assign bus.in_ready = (state == ST_RUN) && !stop && room;
    assign accept     = bus.in_valid && bus.in_ready;
    assign write      = s1_valid && enc_in_range;
    assign last_write = write && (wr_ptr == LAST_PTR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            wr_ptr        <= BASE_PTR;
            count         <= '0;
            err_range     <= 1'b0;
            full          <= 1'b0;
            s1_valid      <= 1'b0;
            s1_src        <= 2'b00;
            s1_imm        <= 32'h0;
            s1_op         <= 7'h0;
            s1_rd         <= 5'h0;
            s1_rs1        <= 5'h0;
            s1_rs2        <= 5'h0;
            s1_funct3     <= 3'h0;
            s1_funct7     <= 7'h0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'h0;
        end else begin
            s1_valid   <= accept;
            bus.mem_we <= write;

            if (accept) begin
                s1_src    <= bus.ImmSrc;
                s1_imm    <= bus.imm;
                s1_op     <= bus.op;
                s1_rd     <= bus.rd;
                s1_rs1    <= bus.rs1;
                s1_rs2    <= bus.rs2;
                s1_funct3 <= bus.funct3;
                s1_funct7 <= bus.funct7;
            end

            if (write) begin
                bus.mem_addr  <= wr_ptr[ADDR_W-1:0];
                bus.mem_wdata <= enc_word;
                wr_ptr        <= wr_ptr + 1'b1;
                count         <= count + 1'b1;
            end

            if (s1_valid && !enc_in_range) begin
                err_range <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_RUN;
                        wr_ptr    <= BASE_PTR;
                        count     <= '0;
                        err_range <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // The last-address write takes priority so full always
                    // rises together with that strobe.
                    if (last_write) begin
                        state <= ST_FULL;
                        full  <= 1'b1;
                    end else if (stop) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid) begin
                        state <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        full  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_instr_encoder.sv
// tb/tb_imm_instr_encoder.sv - scoreboard bench for imm_instr_encoder with random fields
module tb_imm_instr_encoder;
    import imm_instr_encoder_pkg::*;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [AW:0] count;
    logic        err_range;
    logic        full;

    imm_instr_encoder_if #(.ADDR_W(AW)) bus ();

    imm_instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .bus       (bus),
        .count     (count),
        .err_range (err_range),
        .full      (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    src;
        logic [31:0]   imm;
        logic [6:0]    op;
        logic [4:0]    rd;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [2:0]    f3;
        logic [6:0]    f7;
        bit            has_word;
        logic [31:0]   word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   model_count = 0;
    bit   model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic bit is_shift(input logic [1:0] src, input logic [2:0] f3);
        return (src == IMM_I) && (f3 == 3'd1 || f3 == 3'd5);
    endfunction

    // Range rules expressed as signed integer intervals
    function automatic bit model_ok(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] im);
        int s;
        s = $signed(im);
        if (is_shift(src, f3)) return im < 32;
        case (src)
            IMM_I, IMM_S: return (s >= -2048) && (s <= 2047);
            IMM_B:        return (im[0] == 1'b0) && (s >= -4096) && (s <= 4095);
            default:      return (im[0] == 1'b0) && (s >= -1048576) && (s <= 1048575);
        endcase
    endfunction

    // The core's immediate extender, applied to a written word
    function automatic logic [31:0] decode_imm(input logic [1:0] src, input logic [2:0] f3, input logic [31:0] w);
        if (is_shift(src, f3)) return {27'h0, w[24:20]};
        case (src)
            IMM_I:   return {{20{w[31]}}, w[31:20]};
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    function automatic exp_t mk(input logic [1:0] src, input logic [31:0] im, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input bit has_word, input logic [31:0] word);
        exp_t e;
        e.addr = '0; e.src = src; e.imm = im; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.f7 = f7; e.has_word = has_word; e.word = word;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Called at negedge+1; presents the fields and samples in_ready just before each edge.
    task automatic send(input exp_t f, input int budget, output bit ok);
        bus.in_valid = 1'b1;
        bus.ImmSrc = f.src; bus.imm = f.imm; bus.op = f.op; bus.rd = f.rd;
        bus.rs1 = f.rs1; bus.rs2 = f.rs2; bus.funct3 = f.f3; bus.funct7 = f.f7;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            #3;
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            step();
        end
        bus.in_valid = 1'b0;
        if (ok) begin
            if (model_ok(f.src, f.f3, f.imm)) begin
                f.addr = AW'(model_count);
                model_count++;
                sb.push_back(f);
            end else begin
                model_err = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] rand_imm(input logic [1:0] src, input logic [2:0] f3);
        logic [31:0] edges [14];
        int sel;
        edges = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFE, 32'hFFF, 32'h1000,
                  32'hFFFFF000, 32'hFFFFEFFE, 32'hFFFFE, 32'h100000, 32'hFFF00000, 32'd31, 32'd32};
        sel = $urandom_range(0, 9);
        if (sel < 5) begin
            if (is_shift(src, f3)) return 32'($urandom_range(0, 31));
            case (src)
                IMM_I, IMM_S: return 32'($urandom_range(0, 4095)) - 32'd2048;
                IMM_B:        return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
                default:      return (32'($urandom_range(0, 1048575)) - 32'h80000) << 1;
            endcase
        end else if (sel < 8) begin
            return edges[$urandom_range(0, 13)];
        end
        return $urandom;
    endfunction

    task automatic send_random(input int budget, output bit ok);
        logic [1:0] src;
        logic [2:0] f3;
        logic [6:0] op;
        src = 2'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        case (src)
            IMM_I:   op = ($urandom_range(0, 1) == 0) ? OP_IMM : OP_LOAD;
            IMM_S:   op = OP_STORE;
            IMM_B:   op = OP_BRANCH;
            default: op = OP_JAL;
        endcase
        send(mk(src, rand_imm(src, f3), op, 5'($urandom), 5'($urandom), 5'($urandom), f3,
                7'($urandom), 1'b0, 32'h0), budget, ok);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_count = 0;
        model_err = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
    endtask

    // Monitor: pops the scoreboard on every strobe and decodes the written word
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [31:0] w;
        if (reset_n && bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data 0x%08h required=no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = sb.pop_front();
                w = bus.mem_wdata;
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_imm_decoded", decode_imm(e.src, e.f3, w), e.imm);
                check("wr_op", 32'(w[6:0]), 32'(e.op));
                if (e.src != IMM_J) check("wr_funct3", 32'(w[14:12]), 32'(e.f3));
                if (e.src != IMM_J) check("wr_rs1", 32'(w[19:15]), 32'(e.rs1));
                if (e.src == IMM_I || e.src == IMM_J) check("wr_rd", 32'(w[11:7]), 32'(e.rd));
                if (e.src == IMM_S || e.src == IMM_B) check("wr_rs2", 32'(w[24:20]), 32'(e.rs2));
                if (is_shift(e.src, e.f3)) check("wr_funct7", 32'(w[31:25]), 32'(e.f7));
                if (e.has_word) check("wr_word", w, e.word);
                check("full_with_strobe", 32'(full), (32'(e.addr) == DEPTH - 1) ? 32'd1 : 32'd0);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit ok;
        int acc;
        int early;
        int n;

        bus.in_valid = 1'b0; bus.ImmSrc = 2'b00; bus.imm = 32'h0; bus.op = 7'h0; bus.rd = 5'h0;
        bus.rs1 = 5'h0; bus.rs2 = 5'h0; bus.funct3 = 3'h0; bus.funct7 = 7'h0;

        repeat (3) @(posedge clk);
        step();
        reset_n = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err_range", 32'(err_range), 32'd0);
        check("rst_full", 32'(full), 32'd0);

        // addi x1,x0,5 with two-cycle latency
        pulse_start();
        send(mk(IMM_I, 32'd5, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h00500093), 4, ok);
        check("addi_accept", 32'(ok), 32'd1);
        check("addi_not_yet", 32'(bus.mem_we), 32'd0);
        step();
        check("addi_strobe", 32'(bus.mem_we), 32'd1);
        check("addi_count", 32'(count), 32'd1);
        pulse_stop();

        // sw x2,8(x1) then beq x0,x0,-4
        pulse_start();
        send(mk(IMM_S, 32'd8, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 1'b1, 32'h0020A423), 4, ok);
        check("sw_accept", 32'(ok), 32'd1);
        send(mk(IMM_B, 32'hFFFFFFFC, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'hFE000EE3), 4, ok);
        check("beq_accept", 32'(ok), 32'd1);
        repeat (3) step();
        check("sb_count", 32'(count), 32'd2);
        pulse_stop();

        // jal x1,2048; odd J immediate and I immediate 2048 rejected
        pulse_start();
        send(mk(IMM_J, 32'h800, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'h001000EF), 4, ok);
        send(mk(IMM_J, 32'd3, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'h0), 4, ok);
        repeat (3) step();
        check("jodd_err", 32'(err_range), 32'd1);
        check("jodd_count", 32'(count), 32'd1);
        send(mk(IMM_I, 32'd2048, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'h0), 4, ok);
        send(mk(IMM_I, 32'hFFFFFFFF, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 1'b1, 32'hFFF00193), 4, ok);
        repeat (3) step();
        check("rej_then_valid_count", 32'(count), 32'd2);
        check("rej_err_sticky", 32'(err_range), 32'd1);
        pulse_stop();
        pulse_start();
        check("start_clears_err", 32'(err_range), 32'd0);
        check("start_clears_count", 32'(count), 32'd0);
        pulse_stop();

        // Six back-to-back words into a four-word memory
        pulse_start();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(mk(IMM_I, 32'(i), OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 1'b0, 32'h0), 6, ok);
            if (ok) begin
                acc++;
                if (acc == 4) check("ready_low_after_fourth", 32'(bus.in_ready), 32'd0);
            end
        end
        step();
        check("burst_accepts", 32'(acc), 32'd4);
        check("burst_full", 32'(full), 32'd1);
        check("burst_count", 32'(count), 32'd4);
        pulse_stop();
        check("stop_clears_full", 32'(full), 32'd0);
        check("idle_ready_low", 32'(bus.in_ready), 32'd0);

        // Randomized runs, some stopped early through DRAIN
        for (int r = 0; r < 25; r++) begin
            pulse_start();
            early = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 100;
            n = 0;
            while (model_count < DEPTH && n < early) begin
                repeat ($urandom_range(0, 1)) step();
                send_random(8, ok);
                n++;
                if (!ok) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout actual=not accepted required=accepted run=%0d", r);
                    break;
                end
            end
            if (model_count >= DEPTH) begin
                repeat (3) step();
                check("rnd_full", 32'(full), 32'd1);
                check("rnd_count", 32'(count), 32'(model_count));
                check("rnd_err", 32'(err_range), 32'(model_err));
                pulse_stop();
            end else begin
                bus.in_valid = 1'b1;
                stop = 1'b1;
                #3;
                check("stop_beats_valid", 32'(bus.in_ready), 32'd0);
                @(posedge clk);
                step();
                stop = 1'b0;
                bus.in_valid = 1'b0;
                repeat (2) step();
                check("drain_full", 32'(full), 32'd0);
                check("drain_count", 32'(count), 32'(model_count));
                check("drain_err", 32'(err_range), 32'(model_err));
            end
            bus.in_valid = 1'b1;
            #3;
            check("rnd_idle_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            step();
            bus.in_valid = 1'b0;
        end

        // Reset while two words are in the pipeline
        pulse_start();
        bus.in_valid = 1'b1; bus.ImmSrc = IMM_I; bus.imm = 32'd7; bus.op = OP_IMM; bus.rd = 5'd2;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        sb.delete();
        bus.in_valid = 1'b0;
        step();
        check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_full", 32'(full), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_rst_idle", 32'(bus.in_ready), 32'd0);
        pulse_start();
        send(mk(IMM_S, 32'hFFFFF800, OP_STORE, 5'd0, 5'd4, 5'd5, 3'd2, 7'd0, 1'b0, 32'h0), 4, ok);
        check("post_rst_accept", 32'(ok), 32'd1);
        repeat (3) step();
        check("post_rst_count", 32'(count), 32'd1);
        pulse_stop();

        repeat (3) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
